// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReady
  } ld_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Number of word-index bits needed to address a storage array of the given depth.
  function automatic int unsigned idx_width(int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Load-beat handshake and fetch request/response signals of the instruction-memory loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  ld_start;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;
  logic                  ld_err;
  logic                  prog_loaded;

  logic                  if_req;
  logic                  if_stall;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  if_fault;

  modport master (
    output ld_start, ld_valid, ld_addr, ld_data, ld_last,
    output if_req, if_stall, if_addr,
    input  ld_ready, ld_err, prog_loaded,
    input  if_rdata, if_valid, if_fault
  );

  modport slave (
    input  ld_start, ld_valid, ld_addr, ld_data, ld_last,
    input  if_req, if_stall, if_addr,
    output ld_ready, ld_err, prog_loaded,
    output if_rdata, if_valid, if_fault
  );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one combinational read port, no reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned DATA_WIDTH  = 32,
  localparam int unsigned IdxW       = idx_width(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IdxW-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IdxW-1:0]       raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// Program loader and fetch port for a small instruction memory. Per-word loaded bits gate
// visibility, so a fresh session hides stale contents without clearing the storage array.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);

  localparam int unsigned IdxW = idx_width(DEPTH_WORDS);
  localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(NOP_INSN);
  // One extra bit so the byte limit never wraps when it equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] ByteLimit = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

  function automatic logic addr_ok(logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} < ByteLimit);
  endfunction

  ld_state_e             state_q;
  logic [DEPTH_WORDS-1:0] loaded_q;
  logic                  ld_err_q;
  logic                  prog_loaded_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic                  if_valid_q;
  logic                  if_fault_q;

  logic                  beat;
  logic                  ld_ok;
  logic                  fetch_ok;
  logic [IdxW-1:0]       ld_idx;
  logic [IdxW-1:0]       if_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  assign beat     = bus.ld_valid && (state_q == StLoad);
  assign ld_ok    = addr_ok(bus.ld_addr);
  assign fetch_ok = addr_ok(bus.if_addr);
  assign ld_idx   = bus.ld_addr[IdxW+1:2];
  assign if_idx   = bus.if_addr[IdxW+1:2];

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (beat && ld_ok),
    .waddr(ld_idx),
    .wdata(bus.ld_data),
    .raddr(if_idx),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      loaded_q      <= '0;
      ld_err_q      <= 1'b0;
      prog_loaded_q <= 1'b0;
      if_rdata_q    <= Nop;
      if_valid_q    <= 1'b0;
      if_fault_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StReady: begin
          if (bus.ld_start) begin
            state_q       <= StLoad;
            loaded_q      <= '0;
            ld_err_q      <= 1'b0;
            prog_loaded_q <= 1'b0;
            if_rdata_q    <= Nop;
            if_valid_q    <= 1'b0;
            if_fault_q    <= 1'b0;
          end else if (!bus.if_stall) begin
            if_valid_q <= bus.if_req;
            if_fault_q <= bus.if_req && !fetch_ok;
            if_rdata_q <= (bus.if_req && fetch_ok && loaded_q[if_idx]) ? rd_data : Nop;
          end
        end
        StLoad: begin
          // Fetch port is parked while a program is being written.
          if_rdata_q <= Nop;
          if_valid_q <= 1'b0;
          if_fault_q <= 1'b0;
          if (beat) begin
            if (ld_ok) begin
              loaded_q[ld_idx] <= 1'b1;
            end else begin
              ld_err_q <= 1'b1;
            end
            if (bus.ld_last) begin
              state_q       <= StReady;
              prog_loaded_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ld_ready    = (state_q == StLoad);
  assign bus.ld_err      = ld_err_q;
  assign bus.prog_loaded = prog_loaded_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_fault    = if_fault_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a behavioural model pushes expected fetch responses,
// each scenario task pops and compares them once the DUT has responded.
module tb_imem_loader;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] rdata;
    logic        valid;
    logic        fault;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  imem_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  resp_t       sb[$];
  resp_t       last_exp;
  logic [31:0] m_mem[DEPTH];
  logic        m_loaded[DEPTH];
  int          m_state;  // 0 idle, 1 load, 2 ready
  logic        m_err;
  logic        m_prog;

  task automatic model_reset();
    m_state = 0;
    foreach (m_loaded[i]) m_loaded[i] = 1'b0;
    m_err    = 1'b0;
    m_prog   = 1'b0;
    last_exp = {NOP, 1'b0, 1'b0};
    sb.delete();
  endtask

  // Drive one fetch cycle at a falling edge; returns at the next falling edge with the response.
  task automatic drive_fetch(input logic [31:0] addr, input logic req, input logic stall);
    resp_t e;
    logic  f;
    bus.if_addr  = addr;
    bus.if_req   = req;
    bus.if_stall = stall;
    f = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
    if (m_state == 1)  e = {NOP, 1'b0, 1'b0};
    else if (stall)    e = last_exp;
    else if (!req)     e = {NOP, 1'b0, 1'b0};
    else if (f)        e = {NOP, 1'b1, 1'b1};
    else               e = {m_loaded[addr[7:2]] ? m_mem[addr[7:2]] : NOP, 1'b1, 1'b0};
    last_exp = e;
    sb.push_back(e);
    @(negedge clk);
    bus.if_req   = 1'b0;
    bus.if_stall = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] addr, input logic [31:0] data, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    bus.ld_last  = last;
    if (m_state == 1) begin
      if (addr[1:0] == 2'b00 && addr < 32'(4 * DEPTH)) begin
        m_mem[addr[7:2]]    = data;
        m_loaded[addr[7:2]] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      if (last) begin
        m_state = 2;
        m_prog  = 1'b1;
      end
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic drive_start();
    bus.ld_start = 1'b1;
    if (m_state != 1) begin
      m_state = 1;
      foreach (m_loaded[i]) m_loaded[i] = 1'b0;
      m_err    = 1'b0;
      m_prog   = 1'b0;
      last_exp = {NOP, 1'b0, 1'b0};
    end
    @(negedge clk);
    bus.ld_start = 1'b0;
  endtask

  task automatic test_reset();
    resp_t got, e;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.ld_ready !== 1'b0 || bus.ld_err !== 1'b0 || bus.prog_loaded !== 1'b0 ||
        bus.if_valid !== 1'b0 || bus.if_fault !== 1'b0 || bus.if_rdata !== NOP) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b err=%b prog=%b v=%b f=%b rd=%h, exp 0/0/0/0/0/%h",
               bus.ld_ready, bus.ld_err, bus.prog_loaded, bus.if_valid, bus.if_fault,
               bus.if_rdata, NOP);
    end
    rst_n = 1'b1;
    @(negedge clk);
    drive_fetch(32'h0, 1'b1, 1'b0);
    got = {bus.if_rdata, bus.if_valid, bus.if_fault};
    e   = sb.pop_front();
    n_tests++;
    if (got !== e || bus.prog_loaded !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fetch0: got %h/%b/%b prog=%b, exp %h/%b/%b prog=0",
               got.rdata, got.valid, got.fault, bus.prog_loaded, e.rdata, e.valid, e.fault);
    end
  endtask

  task automatic test_load();
    logic [31:0] addrs[3];
    resp_t       got, e;
    addrs = '{32'h04, 32'h1C, 32'h08};
    drive_start();
    n_tests++;
    if (bus.ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ready: got %b, exp 1", bus.ld_ready);
    end
    drive_beat(32'h1C, 32'h0094_8663, 1'b0);
    drive_beat(32'h04, 32'h0198_06B3, 1'b1);
    n_tests++;
    if (bus.prog_loaded !== 1'b1 || bus.ld_ready !== 1'b0 || bus.ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done: got prog=%b rdy=%b err=%b, exp 1/0/0",
               bus.prog_loaded, bus.ld_ready, bus.ld_err);
    end
    foreach (addrs[i]) begin
      drive_fetch(addrs[i], 1'b1, 1'b0);
      got = {bus.if_rdata, bus.if_valid, bus.if_fault};
      e   = sb.pop_front();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL load_fetch addr=%h: got %h/%b/%b, exp %h/%b/%b",
                 addrs[i], got.rdata, got.valid, got.fault, e.rdata, e.valid, e.fault);
      end
    end
  endtask

  task automatic test_stall();
    resp_t got, e;
    drive_fetch(32'h04, 1'b1, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive_fetch(32'h1C + 32'(i * 4), 1'($urandom_range(0, 1)), 1'b1);
      got = {bus.if_rdata, bus.if_valid, bus.if_fault};
      e   = sb.pop_front();
      n_tests++;
      if (got !== e || got.rdata !== 32'h0198_06B3 || got.valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d: got %h/%b/%b, exp %h/1/0",
                 i, got.rdata, got.valid, got.fault, 32'h0198_06B3);
      end
    end
    drive_fetch(32'h1C, 1'b0, 1'b0);
    got = {bus.if_rdata, bus.if_valid, bus.if_fault};
    e   = sb.pop_front();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL stall_release_idle: got %h/%b/%b, exp %h/%b/%b",
               got.rdata, got.valid, got.fault, e.rdata, e.valid, e.fault);
    end
  endtask

  task automatic test_bad_beats();
    logic [31:0] addrs[3];
    resp_t       got, e;
    addrs = '{32'h06, 32'h100, 32'h04};
    drive_start();
    drive_beat(32'h06, 32'hAAAA_0001, 1'b0);
    drive_beat(32'h100, 32'hAAAA_0002, 1'b0);
    drive_beat(32'h04, 32'h0198_06B3, 1'b0);
    drive_beat(32'h1C, 32'h0094_8663, 1'b1);
    n_tests++;
    if (bus.ld_err !== 1'b1 || bus.ld_err !== m_err || bus.prog_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_beat_err: got err=%b prog=%b, exp 1/1", bus.ld_err, bus.prog_loaded);
    end
    foreach (addrs[i]) begin
      drive_fetch(addrs[i], 1'b1, 1'b0);
      got = {bus.if_rdata, bus.if_valid, bus.if_fault};
      e   = sb.pop_front();
      n_tests++;
      if (got !== e || (i < 2 && (got.fault !== 1'b1 || got.rdata !== NOP))) begin
        n_fail++;
        $display("FAIL bad_fetch addr=%h: got %h/%b/%b, exp %h/%b/%b",
                 addrs[i], got.rdata, got.valid, got.fault, e.rdata, e.valid, e.fault);
      end
    end
  endtask

  task automatic test_reload();
    logic [31:0] addrs[4];
    resp_t       got, e;
    addrs = '{32'h04, 32'h10, 32'h14, 32'h1C};
    drive_start();
    n_tests++;
    if (bus.ld_ready !== 1'b1 || bus.prog_loaded !== 1'b0 || bus.ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_start: got rdy=%b prog=%b err=%b, exp 1/0/0",
               bus.ld_ready, bus.prog_loaded, bus.ld_err);
    end
    drive_fetch(32'h04, 1'b1, 1'b0);
    got = {bus.if_rdata, bus.if_valid, bus.if_fault};
    e   = sb.pop_front();
    n_tests++;
    if (got !== e || got.valid !== 1'b0 || got.rdata !== NOP) begin
      n_fail++;
      $display("FAIL reload_fetch_in_load: got %h/%b/%b, exp %h/0/0",
               got.rdata, got.valid, got.fault, NOP);
    end
    drive_beat(32'h10, 32'hDEAD_BEEF, 1'b0);
    drive_start();  // ignored while loading
    drive_beat(32'h14, 32'h1234_5678, 1'b1);
    foreach (addrs[i]) begin
      drive_fetch(addrs[i], 1'b1, 1'b0);
      got = {bus.if_rdata, bus.if_valid, bus.if_fault};
      e   = sb.pop_front();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reload_fetch addr=%h: got %h/%b/%b, exp %h/%b/%b",
                 addrs[i], got.rdata, got.valid, got.fault, e.rdata, e.valid, e.fault);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic        req;
    resp_t       got, e;
    drive_start();
    for (int i = 0; i < 16; i++) begin
      drive_beat(32'(i * 4), $urandom, 1'(i == 15));
    end
    for (int i = 0; i < 24; i++) begin
      a   = (i < 18) ? 32'(i * 4) : 32'($urandom_range(0, 300));
      req = (i % 5) != 3;
      drive_fetch(a, req, 1'b0);
      got = {bus.if_rdata, bus.if_valid, bus.if_fault};
      e   = sb.pop_front();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL b2b_fetch addr=%h req=%b: got %h/%b/%b, exp %h/%b/%b",
                 a, req, got.rdata, got.valid, got.fault, e.rdata, e.valid, e.fault);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] addrs[2];
    resp_t       got, e;
    addrs = '{32'h20, 32'h24};
    drive_start();
    drive_beat(32'h20, 32'hCAFE_0001, 1'b0);
    drive_beat(32'h24, 32'hCAFE_0002, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.ld_ready !== 1'b0 || bus.prog_loaded !== 1'b0 || bus.ld_err !== 1'b0 ||
        bus.if_valid !== 1'b0 || bus.if_rdata !== NOP) begin
      n_fail++;
      $display("FAIL midload_reset: got rdy=%b prog=%b err=%b v=%b rd=%h, exp 0/0/0/0/%h",
               bus.ld_ready, bus.prog_loaded, bus.ld_err, bus.if_valid, bus.if_rdata, NOP);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (addrs[i]) begin
      drive_fetch(addrs[i], 1'b1, 1'b0);
      got = {bus.if_rdata, bus.if_valid, bus.if_fault};
      e   = sb.pop_front();
      n_tests++;
      if (got !== e || got.rdata !== NOP) begin
        n_fail++;
        $display("FAIL midload_fetch addr=%h: got %h/%b/%b, exp %h/1/0",
                 addrs[i], got.rdata, got.valid, got.fault, NOP);
      end
    end
  endtask

  initial begin
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_stall = 1'b0;
    bus.if_addr  = '0;
    rst_n        = 1'b0;
    test_reset();
    test_load();
    test_stall();
    test_bad_beats();
    test_reload();
    test_back_to_back();
    test_reset_mid_load();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left, exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
